aud_recorder: RTL and testbench

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_pkg.sv | 22 ++
 rtl/i2s_shift_rx.sv | 34 +++
 rtl/aud_recorder.sv | 147 ++++++++++++++
 tb/tb_aud_recorder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio recorder and player datapaths.
// Both sides agree on the sample width, the SRAM address width and the state set.
package aud_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REC   = 3'd2,
    S_SAVE  = 3'd3,
    S_PAUSE = 3'd4
  } aud_state_e;

  // A left half-frame begins where LRC drops from high to low.
  function automatic logic lrc_fall(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/i2s_shift_rx.sv
// Serial-to-parallel receiver for one 16-bit I2S channel word, MSB first.
// done_o fires on the edge that samples the LSB; word_o is the complete word at that edge.
module i2s_shift_rx
  import aud_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              bit_i,
  output logic              done_o,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-2:0] sr_q;
  logic [3:0]        cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q  <= {(DATA_W-1){1'b0}};
      cnt_q <= 4'd0;
    end else if (clr_i) begin
      cnt_q <= 4'd0;
    end else if (en_i) begin
      sr_q  <= {sr_q[DATA_W-3:0], bit_i};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // The LSB is not stored: it goes straight into the word on the final edge.
  assign done_o = en_i & (cnt_q == 4'd15);
  assign word_o = {sr_q, bit_i};

endmodule

// File: rtl/aud_recorder.sv
// Records left-channel samples from an I2S codec ADC into SRAM, one word per frame.
// Controlled by start/pause/stop pulses; stops with a sticky full flag at the last address.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_W
) (
  input  logic                 i_bclk,
  input  logic                 i_rst_n,
  input  logic                 i_lrc,
  input  logic                 i_adcdat,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic                 i_stop,
  output logic [ADDR_BITS-1:0] o_address,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_write,
  output logic                 o_busy,
  output logic                 o_full
);

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  aud_state_e           state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_W-1:0]    data_q;
  logic                 write_q;
  logic                 full_q;
  logic                 pause_q;
  logic                 prev_lrc_q;

  logic                 stop_s;
  logic                 pause_s;
  logic                 start_s;
  logic                 fall_s;
  logic                 shift_en_s;
  logic                 done_s;
  logic [DATA_W-1:0]    word_s;

  // Only the highest-priority pulse of a simultaneous set takes effect.
  assign stop_s     = i_stop;
  assign pause_s    = i_pause & ~i_stop;
  assign start_s    = i_start & ~i_stop & ~i_pause;
  assign fall_s     = lrc_fall(prev_lrc_q, i_lrc);
  assign shift_en_s = (state_q == S_REC);

  i2s_shift_rx u_rx (
    .clk_i   (i_bclk),
    .rst_n_i (i_rst_n),
    .en_i    (shift_en_s),
    .clr_i   (~shift_en_s),
    .bit_i   (i_adcdat),
    .done_o  (done_s),
    .word_o  (word_s)
  );

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_BITS{1'b0}};
      data_q     <= {DATA_W{1'b0}};
      write_q    <= 1'b0;
      full_q     <= 1'b0;
      pause_q    <= 1'b0;
      prev_lrc_q <= 1'b0;
    end else begin
      prev_lrc_q <= i_lrc;
      write_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            addr_q  <= {ADDR_BITS{1'b0}};
            full_q  <= 1'b0;
            pause_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (stop_s) begin
            pause_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (pause_s) begin
              pause_q <= 1'b1;
            end
            if (fall_s) begin
              state_q <= S_REC;
            end
          end
        end
        S_REC: begin
          // A stop abandons the partial word, even on its final bit.
          if (stop_s) begin
            pause_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (pause_s) begin
              pause_q <= 1'b1;
            end
            if (done_s) begin
              data_q  <= word_s;
              write_q <= 1'b1;
              state_q <= S_SAVE;
            end
          end
        end
        S_SAVE: begin
          if (addr_q == ADDR_LAST) begin
            full_q  <= 1'b1;
            pause_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
            if (stop_s) begin
              pause_q <= 1'b0;
              state_q <= S_IDLE;
            end else if (pause_q | pause_s) begin
              pause_q <= 1'b0;
              state_q <= S_PAUSE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_PAUSE: begin
          if (stop_s) begin
            state_q <= S_IDLE;
          end else if (start_s) begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          pause_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_write   = write_q;
  assign o_full    = full_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: a full-width and a 3-bit-address instance share one stimulus
// stream and are checked every cycle against a frame-level model plus literal scenarios.
module tb_aud_recorder;

  localparam int AW0 = 20;
  localparam int AW1 = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_REC = 2, M_SAVE = 3, M_PAUSE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0, lrc = 1'b1, dat = 1'b0;
  logic start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic [15:0] data0, data1;
  logic wr0, wr1, busy0, busy1, full0, full1;

  always #5 clk = ~clk;

  aud_recorder #(.ADDR_BITS(AW0)) dut0 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr0), .o_data(data0), .o_write(wr0), .o_busy(busy0), .o_full(full0)
  );

  aud_recorder #(.ADDR_BITS(AW1)) dut1 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr1), .o_data(data1), .o_write(wr1), .o_busy(busy1), .o_full(full1)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model, one slot per instance.
  int m_mode[2], m_nb[2], m_acc[2], m_addr[2], m_data[2], m_last[2];
  bit m_pend[2], m_wr[2], m_full[2];
  bit m_prev;
  int wa0[$], wd0[$], wa1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int last_a0();
    return (wa0.size() > 0) ? wa0[$] : -1;
  endfunction

  function automatic int last_d0();
    return (wd0.size() > 0) ? wd0[$] : -1;
  endfunction

  task automatic model_reset();
    m_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_nb[k] = 0; m_acc[k] = 0; m_addr[k] = 0;
      m_data[k] = 0; m_pend[k] = 1'b0; m_wr[k] = 1'b0; m_full[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit fall, st, pa, sa;
    fall = m_prev && !lrc;
    st = stop;
    pa = pause && !stop;
    sa = start && !stop && !pause;
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 1'b0;
      case (m_mode[k])
        M_IDLE: if (sa) begin
          m_addr[k] = 0; m_full[k] = 1'b0; m_pend[k] = 1'b0; m_mode[k] = M_WAIT;
        end
        M_WAIT: if (st) begin
          m_mode[k] = M_IDLE; m_pend[k] = 1'b0;
        end else begin
          if (pa) m_pend[k] = 1'b1;
          if (fall) begin m_nb[k] = 0; m_acc[k] = 0; m_mode[k] = M_REC; end
        end
        M_REC: if (st) begin
          m_mode[k] = M_IDLE; m_pend[k] = 1'b0;
        end else begin
          if (pa) m_pend[k] = 1'b1;
          m_acc[k] = m_acc[k] * 2 + int'(dat);
          m_nb[k]++;
          if (m_nb[k] == 16) begin
            m_data[k] = m_acc[k] & 32'hFFFF; m_wr[k] = 1'b1; m_mode[k] = M_SAVE;
          end
        end
        M_SAVE: if (m_addr[k] == m_last[k]) begin
          m_full[k] = 1'b1; m_mode[k] = M_IDLE; m_pend[k] = 1'b0;
        end else begin
          m_addr[k]++;
          if (st) begin m_mode[k] = M_IDLE; m_pend[k] = 1'b0; end
          else if (m_pend[k] || pa) begin m_mode[k] = M_PAUSE; m_pend[k] = 1'b0; end
          else m_mode[k] = M_WAIT;
        end
        M_PAUSE: if (st) m_mode[k] = M_IDLE;
                 else if (sa) m_mode[k] = M_WAIT;
        default: m_mode[k] = M_IDLE;
      endcase
    end
    m_prev = lrc;
  endtask

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("address0", 32'(addr0), m_addr[0]);
      chk("data0", 32'(data0), m_data[0]);
      chk("write0", 32'(wr0), 32'(m_wr[0]));
      chk("busy0", 32'(busy0), 32'(m_mode[0] != M_IDLE));
      chk("full0", 32'(full0), 32'(m_full[0]));
      chk("address1", 32'(addr1), m_addr[1]);
      chk("data1", 32'(data1), m_data[1]);
      chk("write1", 32'(wr1), 32'(m_wr[1]));
      chk("busy1", 32'(busy1), 32'(m_mode[1] != M_IDLE));
      chk("full1", 32'(full1), 32'(m_full[1]));
      if (wr0 === 1'b1) begin wa0.push_back(int'(addr0)); wd0.push_back(int'(data0)); end
      if (wr1 === 1'b1) wa1.push_back(int'(addr1));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
  endtask

  task automatic idle_cyc(input int n, input bit do_start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b1; lrc = 1'b1; dat = 1'($urandom);
      start = do_start && (i == 0); pause = 1'b0; stop = 1'b0;
      tick();
    end
  endtask

  // One 32-bit I2S frame; kind 1 start, 2 pause, 3 stop, 4 all three, 5 async reset.
  task automatic frame(input logic [15:0] left, input logic [15:0] right, input int pc,
                       input int pk, input bit rnd, output int nw, output int wcyc,
                       output logic bsy);
    int kind, r;
    nw = 0; wcyc = -1; bsy = 1'bx;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      lrc = (c >= 16);
      if (c >= 1 && c <= 16) dat = left[16-c];
      else if (c >= 17) dat = right[32-c];
      else dat = 1'b0;
      kind = (c == pc) ? pk : 0;
      if (rnd) begin
        r = int'($urandom_range(0, 199));
        kind = (r < 3) ? 1 : (r == 3) ? 2 : (r == 4) ? 3 : (r == 5) ? 5 : 0;
      end
      start = (kind == 1 || kind == 4);
      pause = (kind == 2 || kind == 4);
      stop  = (kind == 3 || kind == 4);
      if (kind == 5) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_address0", 32'(addr0), 32'd0);
        chk("rst_async_data0", 32'(data0), 32'd0);
        chk("rst_async_write0", 32'(wr0), 32'd0);
        chk("rst_async_busy0", 32'(busy0), 32'd0);
        chk("rst_async_full1", 32'(full1), 32'd0);
      end
      tick();
      #1;
      if (wr0 === 1'b1) begin nw++; wcyc = c; end
      if (c == pc) bsy = busy0;
    end
  endtask

  initial begin
    int nw, wc, n7ffe;
    logic b;
    m_last[0] = (1 << AW0) - 1;
    m_last[1] = (1 << AW1) - 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_address", 32'(addr0), 32'd0);
    chk("reset_data", 32'(data0), 32'd0);
    chk("reset_write", 32'(wr0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_full", 32'(full0), 32'd0);
    chk_on = 1'b1;
    idle_cyc(3, 1'b0);
    idle_cyc(2, 1'b1);

    frame(16'hA5C3, 16'h3C5A, -1, 0, 1'b0, nw, wc, b);
    chk("first_word_writes", nw, 1);
    chk("first_word_latency", wc, 16);
    chk("first_word_addr", last_a0(), 0);
    chk("first_word_data", last_d0(), 32'hA5C3);
    chk("first_word_next_addr", 32'(addr0), 32'd1);

    frame(16'h8001, 16'h7FFE, -1, 0, 1'b0, nw, wc, b);
    chk("left_only_writes", nw, 1);
    chk("left_only_data", last_d0(), 32'h8001);
    chk("left_only_addr", last_a0(), 1);

    frame(16'h8001, 16'h7FFE, 7, 2, 1'b0, nw, wc, b);
    chk("pause_word_writes", nw, 1);
    chk("pause_word_addr", last_a0(), 2);
    chk("pause_state_busy", 32'(busy0), 32'd1);
    chk("pause_addr", 32'(addr0), 32'd3);
    frame(16'h1234, 16'h5678, -1, 0, 1'b0, nw, wc, b);
    chk("paused_no_write", nw, 0);
    idle_cyc(1, 1'b1);
    frame(16'h0F0F, 16'hF0F0, -1, 0, 1'b0, nw, wc, b);
    chk("resume_addr", last_a0(), 3);
    chk("resume_data", last_d0(), 32'h0F0F);
    n7ffe = 0;
    foreach (wd0[i]) if (wd0[i] == 32'h7FFE) n7ffe++;
    chk("right_never_written", n7ffe, 0);

    frame(16'hFFFF, 16'h0000, 10, 3, 1'b0, nw, wc, b);
    chk("stop_no_write", nw, 0);
    chk("stop_busy_next", 32'(b), 32'd0);
    chk("stop_addr_count", 32'(addr0), 32'd4);

    idle_cyc(1, 1'b1);
    frame(16'hAAAA, 16'h5555, 5, 4, 1'b0, nw, wc, b);
    chk("triple_no_write", nw, 0);
    chk("triple_idle", 32'(b), 32'd0);
    chk("triple_addr", 32'(addr0), 32'd0);

    idle_cyc(1, 1'b1);
    frame(16'h5555, 16'hAAAA, 8, 5, 1'b0, nw, wc, b);
    chk("reset_mid_no_write", nw, 0);
    chk("reset_mid_busy", 32'(busy0), 32'd0);

    idle_cyc(1, 1'b1);
    wa1.delete();
    for (int i = 0; i < 8; i++) frame(16'($urandom), 16'($urandom), -1, 0, 1'b0, nw, wc, b);
    chk("full_writes", wa1.size(), 8);
    if (wa1.size() == 8) begin
      chk("full_penult_addr", wa1[6], 6);
      chk("full_last_addr", wa1[7], 7);
    end
    chk("full_flag", 32'(full1), 32'd1);
    chk("full_idle", 32'(busy1), 32'd0);
    chk("full_addr_sat", 32'(addr1), 32'd7);
    chk("wide_not_full", 32'(full0), 32'd0);
    chk("wide_addr", 32'(addr0), 32'd8);
    frame(16'($urandom), 16'($urandom), -1, 0, 1'b0, nw, wc, b);
    chk("full_no_more", wa1.size(), 8);
    chk("full_addr_hold", 32'(addr1), 32'd7);
    chk("wide_continues", 32'(addr0), 32'd9);

    idle_cyc(1, 1'b1);
    for (int i = 0; i < 100; i++) frame(16'($urandom), 16'($urandom), -1, 0, 1'b1, nw, wc, b);
    idle_cyc(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
